// File: rtl/bcd_countdown_timer_pkg.sv
// Shared constants, state encoding and helpers for the BCD countdown timer.
package bcd_countdown_timer_pkg;

    localparam logic [3:0] BCD_MAX  = 4'd9;
    localparam logic [3:0] BCD_ZERO = 4'd0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_EXPIRED = 2'd3
    } state_t;

    function automatic logic bcd_digit_valid(input logic [3:0] d);
        return d <= BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit_down.sv
// Single BCD digit with synchronous load and decrement-with-wrap (0 -> 9).
module bcd_digit_down
    import bcd_countdown_timer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ld_i,
    input  logic [3:0] ld_val_i,
    input  logic       dec_i,
    output logic [3:0] q_o,
    output logic       is_zero_o
);

    logic [3:0] q_q;
    logic [3:0] q_d;

    always_comb begin
        q_d = q_q;
        if (ld_i) begin
            q_d = ld_val_i;
        end else if (dec_i) begin
            q_d = (q_q == BCD_ZERO) ? BCD_MAX : q_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q_q <= BCD_ZERO;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o       = q_q;
    assign is_zero_o = (q_q == BCD_ZERO);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer: digit chain with borrow ripple plus run-control FSM.
//   state      | meaning
//   ST_IDLE    | loaded or reset, count held, waiting for start
//   ST_RUN     | ticks decrement the count
//   ST_PAUSED  | count frozen, ticks ignored, start resumes
//   ST_EXPIRED | count reached zero, held until the next load
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load_i,
    input  logic [4*DIGITS-1:0]   load_val_i,
    input  logic                  start_i,
    input  logic                  pause_i,
    input  logic                  tick_i,
    output logic [4*DIGITS-1:0]   cnt_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o
);

    localparam int W = 4 * DIGITS;

    state_t            state_q, state_d;
    logic              busy_q, done_q, done_d, err_q, err_d;
    logic [DIGITS-1:0] dig_zero, dig_dec;
    logic [W-1:0]      dig_ld_val, cnt_w;
    logic              load_bad, cnt_zero, cnt_one, dec_en;

    always_comb begin
        load_bad = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (!bcd_digit_valid(load_val_i[4*k +: 4])) load_bad = 1'b1;
        end
    end

    assign dig_ld_val = load_bad ? '0 : load_val_i;
    assign cnt_zero   = &dig_zero;
    assign cnt_one    = (cnt_w == W'(1));
    // The zero guard means the count can never wrap to all nines.
    assign dec_en     = (state_q == ST_RUN) && tick_i && !pause_i && !load_i && !cnt_zero;

    always_comb begin
        logic borrow;
        borrow  = dec_en;
        dig_dec = '0;
        for (int k = 0; k < DIGITS; k++) begin
            dig_dec[k] = borrow;
            borrow     = borrow & dig_zero[k];
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_digit_down u_digit (
            .clk       (clk),
            .reset_n   (reset_n),
            .ld_i      (load_i),
            .ld_val_i  (dig_ld_val[4*g +: 4]),
            .dec_i     (dig_dec[g]),
            .q_o       (cnt_w[4*g +: 4]),
            .is_zero_o (dig_zero[g])
        );
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        err_d   = err_q;
        if (load_i) begin
            state_d = ST_IDLE;
            err_d   = load_bad;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start_i) begin
                        if (cnt_zero) begin
                            state_d = ST_EXPIRED;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end
                end
                ST_RUN: begin
                    if (pause_i) begin
                        state_d = ST_PAUSED;
                    end else if (dec_en && cnt_one) begin
                        state_d = ST_EXPIRED;
                        done_d  = 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (start_i && !pause_i) state_d = ST_RUN;
                end
                default: state_d = ST_EXPIRED;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == ST_RUN) || (state_d == ST_PAUSED);
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    assign cnt_o  = cnt_w;
    assign busy_o = busy_q;
    assign done_o = done_q;
    assign err_o  = err_q;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Directed bench: integer reference model feeds a scoreboard queue checked after each edge.
module tb_bcd_countdown_timer;

    typedef struct packed {
        logic [7:0] cnt;
        logic       busy;
        logic       done;
        logic       err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        load, start, pause, tick;
    logic [7:0]  load_val;
    logic [11:0] load_val3;
    logic [7:0]  cnt;
    logic [11:0] cnt3;
    logic        busy, done, err, busy3, done3, err3;

    logic [11:0] ov3;
    logic        use_ov;

    int n_checks = 0;
    int n_fail   = 0;
    int done_hits;

    int m_cnt, m_st, m_err, m_done;
    exp_t sb[$];

    always #5 clk = ~clk;

    bcd_countdown_timer #(.DIGITS(2)) dut (
        .clk(clk), .reset_n(reset_n), .load_i(load), .load_val_i(load_val),
        .start_i(start), .pause_i(pause), .tick_i(tick),
        .cnt_o(cnt), .busy_o(busy), .done_o(done), .err_o(err)
    );

    bcd_countdown_timer #(.DIGITS(3)) dut3 (
        .clk(clk), .reset_n(reset_n), .load_i(load), .load_val_i(load_val3),
        .start_i(start), .pause_i(pause), .tick_i(tick),
        .cnt_o(cnt3), .busy_o(busy3), .done_o(done3), .err_o(err3)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] int2bcd(input int v);
        logic [7:0] r;
        r[3:0] = 4'(v % 10);
        r[7:4] = 4'((v / 10) % 10);
        return r;
    endfunction

    task automatic model(input logic ld, input logic [7:0] lv, input logic st,
                         input logic ps, input logic tk);
        m_done = 0;
        if (ld) begin
            if (lv[3:0] <= 4'd9 && lv[7:4] <= 4'd9) begin
                m_cnt = int'(lv[7:4]) * 10 + int'(lv[3:0]);
                m_err = 0;
            end else begin
                m_cnt = 0;
                m_err = 1;
            end
            m_st = 0;
        end else begin
            case (m_st)
                0: if (st) begin
                       if (m_cnt == 0) begin m_st = 3; m_done = 1; end
                       else m_st = 1;
                   end
                1: if (ps) m_st = 2;
                   else if (tk && m_cnt > 0) begin
                       m_cnt--;
                       if (m_cnt == 0) begin m_st = 3; m_done = 1; end
                   end
                2: if (st && !ps) m_st = 1;
                default: ;
            endcase
        end
    endtask

    task automatic step(input logic ld, input logic [7:0] lv, input logic st,
                        input logic ps, input logic tk);
        exp_t e, got;
        @(negedge clk);
        load = ld; load_val = lv; start = st; pause = ps; tick = tk;
        load_val3 = use_ov ? ov3 : {4'h0, lv};
        model(ld, lv, st, ps, tk);
        e.cnt  = int2bcd(m_cnt);
        e.busy = (m_st == 1 || m_st == 2);
        e.done = m_done[0];
        e.err  = m_err[0];
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        if (done === 1'b1) done_hits++;
        chk("cnt",  32'(cnt),  32'(got.cnt));
        chk("busy", 32'(busy), 32'(got.busy));
        chk("done", 32'(done), 32'(got.done));
        chk("err",  32'(err),  32'(got.err));
    endtask

    task automatic idle();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_tick();
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic do_load(input logic [7:0] lv);
        step(1'b1, lv, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic do_start();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        load = 0; start = 0; pause = 0; tick = 0;
        load_val = '0; load_val3 = '0; ov3 = '0; use_ov = 1'b0;
        m_cnt = 0; m_st = 0; m_err = 0; m_done = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cnt",  32'(cnt),  32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_err",  32'(err),  32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Full walk from 25 down to 00
        do_load(8'h25);
        do_start();
        chk("run_busy", 32'(busy), 32'h1);
        done_hits = 0;
        do_tick();
        chk("first_tick", 32'(cnt), 32'h24);
        idle(); idle();
        for (int i = 1; i < 25; i++) begin
            do_tick();
            idle(); idle();
        end
        chk("walk_end_cnt", 32'(cnt), 32'h00);
        chk("walk_done_count", 32'(done_hits), 32'd1);
        chk("walk_busy_end", 32'(busy), 32'h0);

        // Borrow across digits, 2- and 3-digit widths
        ov3 = 12'h100; use_ov = 1'b1;
        do_load(8'h10);
        use_ov = 1'b0;
        do_start();
        do_tick();
        chk("borrow2", 32'(cnt), 32'h09);
        chk("borrow3", 32'(cnt3), 32'h099);
        chk("borrow3_busy", 32'(busy3), 32'h1);

        // Pause holds the count, start resumes
        do_load(8'h05);
        do_start();
        do_tick(); idle(); do_tick();
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        chk("pause_cnt",  32'(cnt),  32'h03);
        chk("pause_busy", 32'(busy), 32'h1);
        step(1'b0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("pause_wins", 32'(busy), 32'h1);
        do_start();
        do_tick(); idle(); do_tick(); idle(); do_tick();
        chk("resume_done", 32'(done), 32'h1);
        chk("resume_cnt",  32'(cnt),  32'h00);
        idle();

        // Invalid load, expiry from zero, then recovery
        do_load(8'h3A);
        chk("bad_err", 32'(err), 32'h1);
        chk("bad_cnt", 32'(cnt), 32'h00);
        do_start();
        chk("zero_start_done", 32'(done), 32'h1);
        do_start();
        chk("expired_no_redone", 32'(done), 32'h0);
        do_tick(); idle();
        do_load(8'h12);
        chk("good_err", 32'(err), 32'h0);
        chk("good_cnt", 32'(cnt), 32'h12);

        // Load during run wins over a coincident tick
        do_load(8'h09);
        do_start();
        do_tick(); do_tick();
        step(1'b1, 8'h40, 1'b0, 1'b0, 1'b1);
        chk("reload_cnt",  32'(cnt),  32'h40);
        chk("reload_busy", 32'(busy), 32'h0);
        do_tick();
        chk("idle_tick", 32'(cnt), 32'h40);

        // Asynchronous reset mid-run
        do_load(8'h15);
        do_start();
        do_tick(); do_tick();
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_cnt",  32'(cnt),  32'h0);
        chk("async_busy", 32'(busy), 32'h0);
        chk("async_done", 32'(done), 32'h0);
        m_cnt = 0; m_st = 0; m_err = 0;
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) do_tick();
        chk("post_rst_cnt", 32'(cnt), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
